// File: rtl/mist_frame_ctl_if.sv
// Signal bundle between the frame sequencer and its consumers (dump
// controller / bench). The sequencer owns the slave side: it samples vs and
// downloading and drives the frame counter, dump window and debug state.
// Handshake: none. vs and downloading are level inputs sampled on every
// rising clk edge; every output is registered and changes only on that edge.
interface mist_frame_ctl_if;
  logic        vs;
  logic        downloading;
  logic [31:0] frame_cnt;
  logic        dump_en;
  logic        dump_start;
  logic        dump_stop;
  logic        finish_req;
  logic [1:0]  state;

  modport master (
    output vs,
    output downloading,
    input  frame_cnt,
    input  dump_en,
    input  dump_start,
    input  dump_stop,
    input  finish_req,
    input  state
  );

  modport slave (
    input  vs,
    input  downloading,
    output frame_cnt,
    output dump_en,
    output dump_start,
    output dump_stop,
    output finish_req,
    output state
  );
endinterface

// File: rtl/mist_frame_ctl.sv
// Frame sequencer: counts vsync falling edges, tracks the ROM download phase
// and opens/closes a dump window, with a one-shot finish request at MAXFRAME.
// State encoding is visible on bus.state (0=LOAD 1=COUNT 2=DUMP 3=DONE).
module mist_frame_ctl #(
  parameter logic [31:0] DUMP_START = 32'd0,
  parameter logic [31:0] DUMP_LEN   = 32'd0,
  parameter logic [31:0] MAXFRAME   = 32'd0,
  parameter logic        WAIT_DL    = 1'b0
) (
  input logic              clk,
  input logic              rst,
  mist_frame_ctl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam state_t ST_RESET = WAIT_DL ? ST_LOAD : ST_COUNT;

  state_t      r_state;
  logic        r_vs_l;
  logic [31:0] r_frame_cnt;
  logic [31:0] r_len_cnt;
  logic        r_dl_seen;
  logic        r_fin_done;
  logic        r_dump_en;
  logic        r_dump_start;
  logic        r_dump_stop;
  logic        r_finish_req;

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [31:0] w_len_nxt;
  logic        w_dl_seen_nxt;
  logic        w_fin_done_nxt;
  logic        w_fin_nxt;
  logic        w_en_nxt;
  logic        w_vs_fall;
  logic [31:0] w_cnt_inc;
  logic [31:0] w_len_inc;

  assign w_vs_fall = r_vs_l & ~bus.vs;
  assign w_cnt_inc = r_frame_cnt + 32'd1;
  assign w_len_inc = r_len_cnt + 32'd1;
  assign w_en_nxt  = (w_state_nxt == ST_DUMP);

  // Next-state, frame/window counters and finish request; download overrides all.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_frame_cnt;
    w_len_nxt      = r_len_cnt;
    w_dl_seen_nxt  = r_dl_seen;
    w_fin_done_nxt = r_fin_done;
    w_fin_nxt      = 1'b0;
    if (bus.downloading) begin
      // The download cycle itself counts as "seen", so LOAD exits on the
      // first idle cycle that follows.
      w_state_nxt    = ST_LOAD;
      w_cnt_nxt      = 32'd0;
      w_dl_seen_nxt  = 1'b1;
      w_fin_done_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (r_dl_seen) begin
            w_state_nxt   = ST_COUNT;
            w_dl_seen_nxt = 1'b0;
          end
        end
        default: begin
          if (w_vs_fall) begin
            w_cnt_nxt = w_cnt_inc;
            if ((MAXFRAME != 32'd0) && (w_cnt_inc == MAXFRAME) && !r_fin_done) begin
              w_fin_nxt      = 1'b1;
              w_fin_done_nxt = 1'b1;
            end
          end
          case (r_state)
            ST_COUNT: begin
              if ((DUMP_START == 32'd0) || (w_vs_fall && (w_cnt_inc == DUMP_START))) begin
                w_state_nxt = ST_DUMP;
                w_len_nxt   = 32'd0;
              end
            end
            ST_DUMP: begin
              if (w_vs_fall) begin
                if ((DUMP_LEN != 32'd0) && (w_len_inc == DUMP_LEN)) begin
                  w_state_nxt = ST_DONE;
                end else begin
                  w_len_nxt = w_len_inc;
                end
              end
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  // State and output registers; pulses are derived from the window edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_vs_l       <= 1'b1;
      r_frame_cnt  <= 32'd0;
      r_len_cnt    <= 32'd0;
      r_dl_seen    <= 1'b0;
      r_fin_done   <= 1'b0;
      r_dump_en    <= 1'b0;
      r_dump_start <= 1'b0;
      r_dump_stop  <= 1'b0;
      r_finish_req <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vs_l       <= bus.vs;
      r_frame_cnt  <= w_cnt_nxt;
      r_len_cnt    <= w_len_nxt;
      r_dl_seen    <= w_dl_seen_nxt;
      r_fin_done   <= w_fin_done_nxt;
      r_dump_en    <= w_en_nxt;
      r_dump_start <= w_en_nxt & ~r_dump_en;
      r_dump_stop  <= ~w_en_nxt & r_dump_en;
      r_finish_req <= w_fin_nxt;
    end
  end

  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.dump_en    = r_dump_en;
  assign bus.dump_start = r_dump_start;
  assign bus.dump_stop  = r_dump_stop;
  assign bus.finish_req = r_finish_req;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mist_frame_ctl.sv
// Bench for mist_frame_ctl: four parameter sets share one vs/downloading
// stimulus; a frame/window reference model predicts every instance each cycle.
module tb_mist_frame_ctl;

  typedef struct packed {
    logic [31:0] cnt;
    logic        en;
    logic        st;
    logic        sp;
    logic        fin;
    logic [1:0]  state;
  } out_t;

  typedef struct {
    logic        vs;
    logic [31:0] cnt;
    logic        en1;
    logic        st1;
    logic        sp1;
    logic [1:0]  state1;
    logic        sp3;
    logic        fin3;
  } vec_t;

  localparam logic [31:0] P_START [4] = '{32'd0, 32'd3, 32'd0, 32'd2};
  localparam logic [31:0] P_LEN   [4] = '{32'd0, 32'd2, 32'd0, 32'd2};
  localparam logic [31:0] P_MAX   [4] = '{32'd0, 32'd0, 32'd0, 32'd4};
  localparam logic        P_WAIT  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  // clock / reset block
  logic clk;
  logic rst;
  logic vs;
  logic downloading;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mist_frame_ctl_if if0 ();
  mist_frame_ctl_if if1 ();
  mist_frame_ctl_if if2 ();
  mist_frame_ctl_if if3 ();

  assign if0.vs = vs;  assign if0.downloading = downloading;
  assign if1.vs = vs;  assign if1.downloading = downloading;
  assign if2.vs = vs;  assign if2.downloading = downloading;
  assign if3.vs = vs;  assign if3.downloading = downloading;

  mist_frame_ctl u0 (.clk(clk), .rst(rst), .bus(if0));
  mist_frame_ctl #(.DUMP_START(32'd3), .DUMP_LEN(32'd2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  mist_frame_ctl #(.WAIT_DL(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  mist_frame_ctl #(.DUMP_START(32'd2), .DUMP_LEN(32'd2), .MAXFRAME(32'd4)) u3 (.clk(clk), .rst(rst), .bus(if3));

  out_t act [4];
  assign act[0] = {if0.frame_cnt, if0.dump_en, if0.dump_start, if0.dump_stop, if0.finish_req, if0.state};
  assign act[1] = {if1.frame_cnt, if1.dump_en, if1.dump_start, if1.dump_stop, if1.finish_req, if1.state};
  assign act[2] = {if2.frame_cnt, if2.dump_en, if2.dump_start, if2.dump_stop, if2.finish_req, if2.state};
  assign act[3] = {if3.frame_cnt, if3.dump_en, if3.dump_start, if3.dump_stop, if3.finish_req, if3.state};

  // scoreboard
  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // reference model: frames counted since last clear, window opened when the
  // start frame is reached, closed after DUMP_LEN further frames
  out_t        exp_o [4];
  logic        m_load [4];
  logic        m_seen [4];
  logic        m_open [4];
  logic        m_closed [4];
  logic        m_fin_done [4];
  logic [31:0] m_cnt [4];
  logic [31:0] m_inwin [4];
  logic        m_vs_prev;

  task automatic model_step(input logic r, input logic v, input logic d);
    logic fall;
    logic prev_en;
    logic fin;
    fall = m_vs_prev && !v;
    for (int i = 0; i < 4; i++) begin
      prev_en = exp_o[i].en;
      fin = 1'b0;
      if (r) begin
        m_load[i] = P_WAIT[i];  m_seen[i] = 1'b0;
        m_cnt[i] = 32'd0;       m_open[i] = 1'b0;  m_closed[i] = 1'b0;
        m_inwin[i] = 32'd0;     m_fin_done[i] = 1'b0;
      end else if (d) begin
        m_load[i] = 1'b1;  m_seen[i] = 1'b1;
        m_cnt[i] = 32'd0;  m_open[i] = 1'b0;  m_closed[i] = 1'b0;
        m_fin_done[i] = 1'b0;
      end else if (m_load[i]) begin
        if (m_seen[i]) begin
          m_load[i] = 1'b0;
          m_seen[i] = 1'b0;
        end
      end else begin
        if (fall) begin
          m_cnt[i] = m_cnt[i] + 32'd1;
          if (P_MAX[i] != 0 && m_cnt[i] == P_MAX[i] && !m_fin_done[i]) begin
            fin = 1'b1;
            m_fin_done[i] = 1'b1;
          end
        end
        if (!m_open[i]) begin
          if (P_START[i] == 0 || (fall && m_cnt[i] == P_START[i])) begin
            m_open[i]  = 1'b1;
            m_inwin[i] = 32'd0;
          end
        end else if (!m_closed[i] && fall) begin
          m_inwin[i] = m_inwin[i] + 32'd1;
          if (P_LEN[i] != 0 && m_inwin[i] == P_LEN[i]) m_closed[i] = 1'b1;
        end
      end
      exp_o[i].cnt   = m_cnt[i];
      exp_o[i].en    = !m_load[i] && m_open[i] && !m_closed[i];
      exp_o[i].st    = !r && exp_o[i].en && !prev_en;
      exp_o[i].sp    = !r && !exp_o[i].en && prev_en;
      exp_o[i].fin   = fin;
      exp_o[i].state = m_load[i] ? 2'd0 : (exp_o[i].en ? 2'd2 : (m_closed[i] ? 2'd3 : 2'd1));
    end
    m_vs_prev = r ? 1'b1 : v;
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cfg%0d.frame_cnt", i),  act[i].cnt,          exp_o[i].cnt);
      chk($sformatf("cfg%0d.dump_en", i),    {31'd0, act[i].en},  {31'd0, exp_o[i].en});
      chk($sformatf("cfg%0d.dump_start", i), {31'd0, act[i].st},  {31'd0, exp_o[i].st});
      chk($sformatf("cfg%0d.dump_stop", i),  {31'd0, act[i].sp},  {31'd0, exp_o[i].sp});
      chk($sformatf("cfg%0d.finish_req", i), {31'd0, act[i].fin}, {31'd0, exp_o[i].fin});
      chk($sformatf("cfg%0d.state", i),      {30'd0, act[i].state}, {30'd0, exp_o[i].state});
    end
  endtask

  // driver: apply one cycle of inputs, advance model, sample #1 after the edge
  task automatic cycle(input logic r, input logic v, input logic d);
    rst = r;
    vs = v;
    downloading = d;
    model_step(r, v, d);
    @(posedge clk);
    #1;
    check_model();
  endtask

  vec_t tbl [12];
  int   dl_left;
  logic r_rnd;
  logic d_rnd;

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_vs_prev = 1'b1;
    for (int i = 0; i < 4; i++) exp_o[i] = '0;
    rst = 1'b1;
    vs = 1'b1;
    downloading = 1'b0;

    // vs pattern and expectations for DUMP_START=3/DUMP_LEN=2 (cfg1), plus
    // the close+finish coincidence of cfg3 on frame 4
    tbl[0]  = '{1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'd3, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'd4, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'd5, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'd6, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};

    // reset values
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0);
    chk("rst.cfg2_state_load", {30'd0, if2.state}, 32'd0);
    chk("rst.cfg0_state_count", {30'd0, if0.state}, 32'd1);
    chk("rst.cfg0_frame_cnt", if0.frame_cnt, 32'd0);

    // first cycle out of reset: default window opens immediately
    cycle(1'b0, 1'b1, 1'b0);
    chk("start.cfg0_dump_start", {31'd0, if0.dump_start}, 32'd1);
    chk("start.cfg0_dump_en", {31'd0, if0.dump_en}, 32'd1);

    // table-driven window open/close sequence
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, tbl[i].vs, 1'b0);
      chk($sformatf("tbl%0d.cnt", i), if1.frame_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d.en1", i), {31'd0, if1.dump_en}, {31'd0, tbl[i].en1});
      chk($sformatf("tbl%0d.st1", i), {31'd0, if1.dump_start}, {31'd0, tbl[i].st1});
      chk($sformatf("tbl%0d.sp1", i), {31'd0, if1.dump_stop}, {31'd0, tbl[i].sp1});
      chk($sformatf("tbl%0d.state1", i), {30'd0, if1.state}, {30'd0, tbl[i].state1});
      chk($sformatf("tbl%0d.sp3", i), {31'd0, if3.dump_stop}, {31'd0, tbl[i].sp3});
      chk($sformatf("tbl%0d.fin3", i), {31'd0, if3.finish_req}, {31'd0, tbl[i].fin3});
    end
    chk("dflt.frame_cnt_6", if0.frame_cnt, 32'd6);

    // download arrives while cfg0 is dumping at frame 7
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("dl.cfg0_cnt7", if0.frame_cnt, 32'd7);
    cycle(1'b0, 1'b1, 1'b1);
    chk("dl.cfg0_stop", {31'd0, if0.dump_stop}, 32'd1);
    chk("dl.cfg0_cnt0", if0.frame_cnt, 32'd0);
    chk("dl.cfg0_load", {30'd0, if0.state}, 32'd0);
    chk("dl.cfg1_no_stop", {31'd0, if1.dump_stop}, 32'd0);

    // download with a simultaneous vs fall, then 10 download cycles
    cycle(1'b0, 1'b0, 1'b1);
    chk("dl_fall.cfg0_cnt0", if0.frame_cnt, 32'd0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, k[0], 1'b1);
      chk($sformatf("wait.cfg2_cnt%0d", k), if2.frame_cnt, 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b0);
    chk("wait.cfg2_count", {30'd0, if2.state}, 32'd1);
    chk("wait.cfg2_cnt_still0", if2.frame_cnt, 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("wait.cfg2_cnt1", if2.frame_cnt, 32'd1);
    chk("wait.cfg0_restart", {31'd0, if0.dump_start}, 32'd1);

    // randomized stimulus against the model
    dl_left = 0;
    for (int k = 0; k < 2000; k++) begin
      r_rnd = ($urandom_range(0, 249) == 0);
      if (dl_left > 0) begin
        d_rnd = 1'b1;
        dl_left--;
      end else if ($urandom_range(0, 119) == 0) begin
        d_rnd = 1'b1;
        dl_left = $urandom_range(0, 5);
      end else begin
        d_rnd = 1'b0;
      end
      cycle(r_rnd, ($urandom_range(0, 3) != 0), d_rnd);
    end

    // frame counter wrap from all-ones
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0);
    force u0.r_frame_cnt = 32'hFFFF_FFFF;
    #1;
    release u0.r_frame_cnt;
    m_cnt[0] = 32'hFFFF_FFFF;
    cycle(1'b0, 1'b0, 1'b0);
    chk("wrap.cfg0_cnt0", if0.frame_cnt, 32'd0);
    chk("wrap.cfg0_en", {31'd0, if0.dump_en}, 32'd1);
    chk("wrap.cfg0_no_start", {31'd0, if0.dump_start}, 32'd0);
    chk("wrap.cfg0_no_stop", {31'd0, if0.dump_stop}, 32'd0);
    chk("wrap.cfg0_no_fin", {31'd0, if0.finish_req}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
